// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation scheduler: FSM states,
// level encoding and the tank-sensor decoder.
package irrigation_pkg;

  localparam int LEVEL_W = 2;
  localparam int BCD_W   = 4;

  localparam logic [LEVEL_W-1:0] LEVEL_EMPTY = 2'd0;
  localparam logic [LEVEL_W-1:0] LEVEL_FULL  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPRINKLE = 3'd1,
    ST_DRIP     = 3'd2,
    ST_FILL     = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [LEVEL_W-1:0] level;
  } sensor_dec_t;

  // Sensors are thermometer coded; any gap in the column is a sensor fault.
  function automatic sensor_dec_t decode_sensors(input logic h, input logic m, input logic l);
    sensor_dec_t r;
    case ({h, m, l})
      3'b000:  r = '{valid: 1'b1, level: 2'd0};
      3'b001:  r = '{valid: 1'b1, level: 2'd1};
      3'b011:  r = '{valid: 1'b1, level: 2'd2};
      3'b111:  r = '{valid: 1'b1, level: 2'd3};
      default: r = '{valid: 1'b0, level: 2'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_mmss_timer.sv
// Elapsed-time counter in BCD mm:ss, wrapping 59:59 -> 00:00.
// clear has priority over en.
module bcd_mmss_timer
  import irrigation_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  output logic [BCD_W-1:0] bcd_s1,
  output logic [BCD_W-1:0] bcd_s10,
  output logic [BCD_W-1:0] bcd_m1,
  output logic [BCD_W-1:0] bcd_m10
);

  logic [BCD_W-1:0] s1_q, s10_q, m1_q, m10_q;

  // Ripple-carry through the four digits on each enabled second.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= 4'd0;
      s10_q <= 4'd0;
      m1_q  <= 4'd0;
      m10_q <= 4'd0;
    end else if (clear) begin
      s1_q  <= 4'd0;
      s10_q <= 4'd0;
      m1_q  <= 4'd0;
      m10_q <= 4'd0;
    end else if (en) begin
      if (s1_q == 4'd9) begin
        s1_q <= 4'd0;
        if (s10_q == 4'd5) begin
          s10_q <= 4'd0;
          if (m1_q == 4'd9) begin
            m1_q  <= 4'd0;
            m10_q <= (m10_q == 4'd5) ? 4'd0 : m10_q + 4'd1;
          end else begin
            m1_q <= m1_q + 4'd1;
          end
        end else begin
          s10_q <= s10_q + 4'd1;
        end
      end else begin
        s1_q <= s1_q + 4'd1;
      end
    end
  end

  assign bcd_s1  = s1_q;
  assign bcd_s10 = s10_q;
  assign bcd_m1  = m1_q;
  assign bcd_m10 = m10_q;

endmodule

// File: rtl/irrigation_scheduler.sv
// Tank/irrigation sequencer: arbitrates sprinkler, drip and refill, tracks a
// 4-step tank level and times the current activity in BCD mm:ss.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int SPRINKLE_STEP_S = 300,
  parameter int DRIP_STEP_S     = 600,
  parameter int FILL_STEP_S     = 60,
  parameter int STEP_W          = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick_1s,
  input  logic             bs_req,
  input  logic             vs_req,
  input  logic             fill_req,
  input  logic             error_in,
  input  logic             load_level,
  input  logic             H,
  input  logic             M,
  input  logic             L,
  output logic             Bs,
  output logic             Vs,
  output logic             fill,
  output logic             Error,
  output logic             empty,
  output logic             lvl_h,
  output logic             lvl_m,
  output logic             lvl_l,
  output logic [BCD_W-1:0] bcd_s1,
  output logic [BCD_W-1:0] bcd_s10,
  output logic [BCD_W-1:0] bcd_m1,
  output logic [BCD_W-1:0] bcd_m10
);

  localparam logic [STEP_W-1:0] SPR_LAST  = STEP_W'(SPRINKLE_STEP_S - 1);
  localparam logic [STEP_W-1:0] DRIP_LAST = STEP_W'(DRIP_STEP_S - 1);
  localparam logic [STEP_W-1:0] FILL_LAST = STEP_W'(FILL_STEP_S - 1);

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               clear_s;
  logic               adv_s;
  logic [STEP_W-1:0]  last_s;
  logic [LEVEL_W-1:0] next_level_s;
  sensor_dec_t        sens_s;

  assign sens_s = decode_sensors(H, M, L);

  // State, level and step-counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      level_q <= LEVEL_EMPTY;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      step_q  <= step_d;
    end
  end

  // Next-state arbitration; a transition on this edge suppresses timer/level updates.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    step_d       = step_q;
    clear_s      = 1'b0;
    adv_s        = 1'b0;
    last_s       = SPR_LAST;
    next_level_s = level_q;

    if (error_in) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_level) begin
            if (sens_s.valid) begin
              level_d = sens_s.level;
            end else begin
              state_d = ST_FAULT;
            end
          end else if (fill_req && (level_q < LEVEL_FULL)) begin
            state_d = ST_FILL;
            clear_s = 1'b1;
          end else if (bs_req && (level_q > LEVEL_EMPTY)) begin
            state_d = ST_SPRINKLE;
            clear_s = 1'b1;
          end else if (vs_req && (level_q > LEVEL_EMPTY)) begin
            state_d = ST_DRIP;
            clear_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SPRINKLE: begin
          last_s = SPR_LAST;
          if (!bs_req) begin
            if (vs_req && (level_q > LEVEL_EMPTY)) begin
              state_d = ST_DRIP;
              clear_s = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            adv_s = tick_1s;
          end
        end
        ST_DRIP: begin
          last_s = DRIP_LAST;
          if (bs_req) begin
            state_d = ST_SPRINKLE;
            clear_s = 1'b1;
          end else if (!vs_req) begin
            state_d = ST_IDLE;
          end else begin
            adv_s = tick_1s;
          end
        end
        ST_FILL: begin
          last_s = FILL_LAST;
          if (!fill_req) begin
            state_d = ST_IDLE;
          end else begin
            adv_s = tick_1s;
          end
        end
        ST_FAULT: begin
          if (load_level && sens_s.valid) begin
            state_d = ST_IDLE;
            level_d = sens_s.level;
          end else begin
            state_d = ST_FAULT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (clear_s) begin
      step_d = '0;
    end else if (adv_s) begin
      if (step_q == last_s) begin
        step_d = '0;
        if (state_q == ST_FILL) begin
          next_level_s = level_q + 2'd1;
          if (next_level_s == LEVEL_FULL) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end else begin
          next_level_s = level_q - 2'd1;
          if (next_level_s == LEVEL_EMPTY) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        level_d = next_level_s;
      end else begin
        step_d = step_q + {{(STEP_W-1){1'b0}}, 1'b1};
      end
    end else begin
      step_d = step_d;
    end
  end

  bcd_mmss_timer u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear_s),
    .en      (adv_s),
    .bcd_s1  (bcd_s1),
    .bcd_s10 (bcd_s10),
    .bcd_m1  (bcd_m1),
    .bcd_m10 (bcd_m10)
  );

  assign Bs    = (state_q == ST_SPRINKLE);
  assign Vs    = (state_q == ST_DRIP);
  assign fill  = (state_q == ST_FILL);
  assign Error = (state_q == ST_FAULT);
  assign empty = (level_q == LEVEL_EMPTY);
  assign lvl_h = (level_q == LEVEL_FULL);
  assign lvl_m = level_q[1];
  assign lvl_l = |level_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler: short-step instance for the
// sequencing scenarios, long-step instance for the 59:59 timer wrap.
module tb_irrigation_scheduler;

  typedef struct {
    string       name;
    bit          sel;
    logic [23:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic tick_1s = 1'b0, bs_req = 1'b0, vs_req = 1'b0, fill_req = 1'b0;
  logic error_in = 1'b0, load_level = 1'b0, H = 1'b0, M = 1'b0, L = 1'b0;
  logic Bs, Vs, fill, Error, empty, lvl_h, lvl_m, lvl_l;
  logic [3:0] bcd_s1, bcd_s10, bcd_m1, bcd_m10;

  logic lg_tick = 1'b0, lg_bs = 1'b0, lg_load = 1'b0, lg_h = 1'b0, lg_m = 1'b0, lg_l = 1'b0;
  logic lg_Bs, lg_Vs, lg_fill, lg_Error, lg_empty, lg_lvl_h, lg_lvl_m, lg_lvl_l;
  logic [3:0] lg_s1, lg_s10, lg_m1, lg_m10;

  always #10 clock = ~clock;

  irrigation_scheduler #(
    .SPRINKLE_STEP_S(3), .DRIP_STEP_S(5), .FILL_STEP_S(2), .STEP_W(10)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .tick_1s(tick_1s), .bs_req(bs_req),
    .vs_req(vs_req), .fill_req(fill_req), .error_in(error_in), .load_level(load_level),
    .H(H), .M(M), .L(L), .Bs(Bs), .Vs(Vs), .fill(fill), .Error(Error), .empty(empty),
    .lvl_h(lvl_h), .lvl_m(lvl_m), .lvl_l(lvl_l), .bcd_s1(bcd_s1), .bcd_s10(bcd_s10),
    .bcd_m1(bcd_m1), .bcd_m10(bcd_m10)
  );

  irrigation_scheduler #(
    .SPRINKLE_STEP_S(4000), .DRIP_STEP_S(4000), .FILL_STEP_S(4000), .STEP_W(12)
  ) u_long (
    .clock(clock), .reset_n(reset_n), .tick_1s(lg_tick), .bs_req(lg_bs),
    .vs_req(1'b0), .fill_req(1'b0), .error_in(1'b0), .load_level(lg_load),
    .H(lg_h), .M(lg_m), .L(lg_l), .Bs(lg_Bs), .Vs(lg_Vs), .fill(lg_fill), .Error(lg_Error),
    .empty(lg_empty), .lvl_h(lg_lvl_h), .lvl_m(lg_lvl_m), .lvl_l(lg_lvl_l),
    .bcd_s1(lg_s1), .bcd_s10(lg_s10), .bcd_m1(lg_m1), .bcd_m10(lg_m10)
  );

  // Expected output vector: actuators, fault, level flags, then mm:ss digits.
  function automatic logic [23:0] ev(input bit bs, input bit vs, input bit fl, input bit er,
                                     input int lvl, input logic [15:0] mmss);
    logic [7:0] flags;
    flags = {bs, vs, fl, er, (lvl == 0), (lvl == 3), (lvl >= 2), (lvl >= 1)};
    return {flags, mmss};
  endfunction

  task automatic chk(input string name, input bit sel, input logic [23:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1s = 1'b1;
      cyc();
    end
    tick_1s = 1'b0;
  endtask

  task automatic load(input logic h, input logic m, input logic l);
    {H, M, L} = {h, m, l};
    load_level = 1'b1;
    cyc();
    load_level = 1'b0;
  endtask

  // Monitor: one queued expectation is compared per falling edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [23:0] act;
      e = exp_q.pop_front();
      act = e.sel ? {lg_Bs, lg_Vs, lg_fill, lg_Error, lg_empty, lg_lvl_h, lg_lvl_m, lg_lvl_l,
                     lg_m10, lg_m1, lg_s10, lg_s1}
                  : {Bs, Vs, fill, Error, empty, lvl_h, lvl_m, lvl_l,
                     bcd_m10, bcd_m1, bcd_s10, bcd_s1};
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s actual=%h expected=%h", e.name, act, e.val);
      end
    end
  end

  initial begin
    repeat (2) cyc();
    chk("reset", 0, ev(0, 0, 0, 0, 0, 16'h0000));
    cyc();
    reset_n = 1'b1;
    cyc();

    load(1, 1, 1);
    chk("load111", 0, ev(0, 0, 0, 0, 3, 16'h0000));
    bs_req = 1'b1;
    cyc();
    chk("bs_accept", 0, ev(1, 0, 0, 0, 3, 16'h0000));
    tick(3);
    chk("spr_t3", 0, ev(1, 0, 0, 0, 2, 16'h0003));
    tick(3);
    chk("spr_t6", 0, ev(1, 0, 0, 0, 1, 16'h0006));
    tick(3);
    chk("spr_t9_empty", 0, ev(0, 0, 0, 0, 0, 16'h0009));
    bs_req = 1'b0;
    cyc();

    load(0, 1, 1);
    chk("load011_hold", 0, ev(0, 0, 0, 0, 2, 16'h0009));
    vs_req = 1'b1;
    cyc();
    chk("drip_accept", 0, ev(0, 1, 0, 0, 2, 16'h0000));
    tick(2);
    chk("drip_t2", 0, ev(0, 1, 0, 0, 2, 16'h0002));
    bs_req = 1'b1;
    tick(1);
    chk("preempt", 0, ev(1, 0, 0, 0, 2, 16'h0000));
    tick(2);
    chk("pre_t2", 0, ev(1, 0, 0, 0, 2, 16'h0002));
    tick(1);
    chk("pre_t3", 0, ev(1, 0, 0, 0, 1, 16'h0003));
    bs_req = 1'b0;
    cyc();
    chk("spr_to_drip", 0, ev(0, 1, 0, 0, 1, 16'h0000));
    vs_req = 1'b0;
    cyc();
    chk("drip_idle", 0, ev(0, 0, 0, 0, 1, 16'h0000));

    load(1, 0, 1);
    chk("bad_pattern", 0, ev(0, 0, 0, 1, 1, 16'h0000));
    error_in = 1'b1;
    load(0, 1, 1);
    chk("fault_hold", 0, ev(0, 0, 0, 1, 1, 16'h0000));
    error_in = 1'b0;
    load(0, 1, 1);
    chk("fault_exit", 0, ev(0, 0, 0, 0, 2, 16'h0000));

    load(0, 0, 1);
    chk("load001", 0, ev(0, 0, 0, 0, 1, 16'h0000));
    fill_req = 1'b1;
    bs_req = 1'b1;
    cyc();
    chk("fill_wins", 0, ev(0, 0, 1, 0, 1, 16'h0000));
    tick(2);
    chk("fill_t2", 0, ev(0, 0, 1, 0, 2, 16'h0002));
    tick(2);
    chk("fill_full", 0, ev(0, 0, 0, 0, 3, 16'h0004));
    cyc();
    chk("full_then_spr", 0, ev(1, 0, 0, 0, 3, 16'h0000));
    fill_req = 1'b0;
    load(0, 0, 0);
    chk("load_ignored", 0, ev(1, 0, 0, 0, 3, 16'h0000));
    error_in = 1'b1;
    tick(1);
    error_in = 1'b0;
    chk("err_beats_tick", 0, ev(0, 0, 0, 1, 3, 16'h0000));
    bs_req = 1'b0;
    cyc();

    load(1, 1, 1);
    chk("recover", 0, ev(0, 0, 0, 0, 3, 16'h0000));
    bs_req = 1'b1;
    cyc();
    tick(2);
    chk("pre_reset", 0, ev(1, 0, 0, 0, 3, 16'h0002));
    cyc();
    reset_n = 1'b0;
    #1;
    chk("async_reset", 0, ev(0, 0, 0, 0, 0, 16'h0000));
    bs_req = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

    {lg_h, lg_m, lg_l} = 3'b111;
    lg_load = 1'b1;
    cyc();
    lg_load = 1'b0;
    lg_bs = 1'b1;
    cyc();
    chk("lg_start", 1, ev(1, 0, 0, 0, 3, 16'h0000));
    lg_tick = 1'b1;
    repeat (3598) cyc();
    lg_tick = 1'b0;
    chk("lg_5958", 1, ev(1, 0, 0, 0, 3, 16'h5958));
    lg_tick = 1'b1;
    repeat (2) cyc();
    lg_tick = 1'b0;
    chk("lg_wrap", 1, ev(1, 0, 0, 0, 3, 16'h0000));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
